renas_ahb_timer: RTL

AHB-lite slave peripheral timer attached to the peripheral slave port of the AHB matrix (`hsel_slave_peri` / `slave_peri_out` / `slave_peri_in`). It answers CPU peripheral-master transfers to a small register bank. It provides a 32-bit down-counter with auto-reload, a sticky expiry flag and a level interrupt. Transfers are zero-wait-state OKAY, or take the two-cycle AHB ERROR response.

---
 rtl/renas_ahb_pkg.sv | 31 +++
 rtl/renas_peri_pkg.sv | 34 +++
 rtl/renas_ahb_slv_itf.sv | 98 +++++++++
 rtl/renas_ahb_timer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/renas_ahb_pkg.sv
// ---------------------------------------------------------------------------
// renas_ahb_pkg
// Shared AHB-lite bus types used by the AHB matrix and its slave peripherals.
//   mas_send_type : master-to-slave signals (address phase plus write data)
//   slv_send_type : slave-to-master response signals
// ---------------------------------------------------------------------------
package renas_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
  } slv_send_type;

endpackage

// File: rtl/renas_peri_pkg.sv
// ---------------------------------------------------------------------------
// renas_peri_pkg
// Constants shared by the renas AHB peripherals: register word offsets,
// CTRL/STATUS bit positions and the two-cycle ERROR response state enum.
// ---------------------------------------------------------------------------
package renas_peri_pkg;

  // Word offsets, i.e. haddr[4:2]
  localparam logic [2:0] OFS_CTRL   = 3'd0;
  localparam logic [2:0] OFS_LOAD   = 3'd1;
  localparam logic [2:0] OFS_COUNT  = 3'd2;
  localparam logic [2:0] OFS_STATUS = 3'd3;
  localparam logic [2:0] OFS_PRESC  = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  // STATUS bit positions
  localparam int STATUS_EXPIRED = 0;

  localparam int PRESC_W = 16;

  // Only full-word accesses are supported by the peripheral register banks
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

endpackage

// File: rtl/renas_ahb_slv_itf.sv
// ---------------------------------------------------------------------------
// renas_ahb_slv_itf
// Generic AHB-lite slave front end for small register-bank peripherals.
// Captures accepted address phases into data-phase registers, checks each
// transfer for decode errors and runs the two-cycle ERROR response.
//
// Parameters
//   ADDR_W   decoded address bits inside the peripheral region (< 32)
//   REG_MAP  bit n set = word offset n is implemented
// Ports
//   hclk, hreset_n   clock, synchronous active-low reset
//   hsel, hready_in  slave select and bus-level HREADY
//   slave_in         master-side bus signals
//   dp_valid         a decode-clean transfer is in its data phase
//   dp_write         that transfer is a write
//   dp_offset        its word offset
//   hreadyout, hresp registered slave response
// ---------------------------------------------------------------------------
module renas_ahb_slv_itf
  import renas_ahb_pkg::*;
  import renas_peri_pkg::*;
#(
  parameter int         ADDR_W  = 12,
  parameter logic [7:0] REG_MAP = 8'h0F
) (
  input  logic         hclk,
  input  logic         hreset_n,
  input  logic         hsel,
  input  logic         hready_in,
  input  mas_send_type slave_in,
  output logic         dp_valid,
  output logic         dp_write,
  output logic [2:0]   dp_offset,
  output logic         hreadyout,
  output logic         hresp
);

  logic       addr_accept;
  logic       addr_err;
  logic [2:0] addr_offset;
  err_state_t err_state;

  // Write data and the address bits above the region are handled elsewhere
  logic unused_itf;
  assign unused_itf = ^{slave_in.haddr[31:ADDR_W], slave_in.htrans[0], slave_in.hwdata};

  assign addr_accept = hsel & slave_in.htrans[1] & hready_in;
  assign addr_offset = slave_in.haddr[4:2];

  assign addr_err = (slave_in.hsize != HSIZE_WORD)
                  | (slave_in.haddr[1:0] != 2'b00)
                  | (slave_in.haddr[ADDR_W-1:5] != '0)
                  | ~REG_MAP[addr_offset];

  // Errored transfers never raise dp_valid, so they cannot touch the
  // register bank. ERR2 behaves like IDLE for a new address phase, which
  // lets a master issue its next transfer in the second error cycle.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      err_state <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_offset <= '0;
    end else begin
      dp_valid <= addr_accept & ~addr_err;
      if (addr_accept) begin
        dp_write  <= slave_in.hwrite;
        dp_offset <= addr_offset;
      end
      case (err_state)
        ST_IDLE, ST_ERR2: begin
          if (addr_accept && addr_err) begin
            err_state <= ST_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end else begin
            err_state <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          err_state <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          err_state <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/renas_ahb_timer.sv
// ---------------------------------------------------------------------------
// renas_ahb_timer
// AHB-lite peripheral timer: 32-bit down-counter with optional auto-reload,
// sticky expiry flag and level interrupt.
//
// Register map (word offset haddr[4:2]):
//   0 CTRL   RW  [0] en, [1] irq_en, [2] auto_reload
//   1 LOAD   RW  writing also loads COUNT
//   2 COUNT  RO
//   3 STATUS     [0] expired, write-1-to-clear
//   4 PRESC  RW  [15:0], only when RENAS_TIMER_PRESCALER_EN is defined
//
// Build option: RENAS_TIMER_PRESCALER_EN adds PRESC and a prescaler that
// ticks the counter every PRESC+1 cycles; otherwise it ticks every cycle.
//
// Ports
//   hclk, hreset_n  clock, synchronous active-low reset
//   hsel            peripheral slave select from the matrix
//   hready_in       bus-level HREADY
//   slave_in        master-side bus signals
//   slave_out       hrdata / hreadyout / hresp
//   timer_irq       expired & irq_en
// ---------------------------------------------------------------------------
module renas_ahb_timer
  import renas_ahb_pkg::*;
  import renas_peri_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
  input  logic         hclk,
  input  logic         hreset_n,
  input  logic         hsel,
  input  logic         hready_in,
  input  mas_send_type slave_in,
  output slv_send_type slave_out,
  output logic         timer_irq
);

`ifdef RENAS_TIMER_PRESCALER_EN
  localparam logic [7:0] REG_MAP = 8'h1F;
`else
  localparam logic [7:0] REG_MAP = 8'h0F;
`endif

  logic        dp_valid;
  logic        dp_write;
  logic [2:0]  dp_offset;
  logic        itf_hreadyout;
  logic        itf_hresp;

  logic        ctrl_en;
  logic        ctrl_irq_en;
  logic        ctrl_auto_reload;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        expired_q;

  logic [31:0] wdata;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        tick;
  logic        expire_evt;
  logic [31:0] rd_data;

  renas_ahb_slv_itf #(
    .ADDR_W  (ADDR_W),
    .REG_MAP (REG_MAP)
  ) u_itf (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hsel      (hsel),
    .hready_in (hready_in),
    .slave_in  (slave_in),
    .dp_valid  (dp_valid),
    .dp_write  (dp_write),
    .dp_offset (dp_offset),
    .hreadyout (itf_hreadyout),
    .hresp     (itf_hresp)
  );

  assign wdata     = slave_in.hwdata;
  assign wr_ctrl   = dp_valid & dp_write & (dp_offset == OFS_CTRL);
  assign wr_load   = dp_valid & dp_write & (dp_offset == OFS_LOAD);
  assign wr_status = dp_valid & dp_write & (dp_offset == OFS_STATUS);

`ifdef RENAS_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic               wr_presc;

  assign wr_presc = dp_valid & dp_write & (dp_offset == OFS_PRESC);
  assign tick     = (presc_cnt == presc_q);

  // Prescaler restarts from 0 whenever the timer is off or PRESC changes,
  // so the first tick after enabling always comes PRESC+1 cycles later.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      presc_q   <= '0;
      presc_cnt <= '0;
    end else begin
      if (wr_presc) begin
        presc_q <= wdata[PRESC_W-1:0];
      end
      if (!ctrl_en || wr_presc || tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign expire_evt = ctrl_en & tick & (count_q == 32'd0);

  // Timer core. Priorities on collisions: a LOAD write beats the tick, a
  // CTRL write beats the hardware clear of en, and the hardware set of
  // expired beats a software W1C.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      ctrl_en          <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      load_q           <= RST_LOAD;
      count_q          <= RST_LOAD;
      expired_q        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en          <= wdata[CTRL_EN];
        ctrl_irq_en      <= wdata[CTRL_IRQ_EN];
        ctrl_auto_reload <= wdata[CTRL_AUTO_RELOAD];
      end else if (expire_evt && !ctrl_auto_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load) begin
        load_q  <= wdata;
        count_q <= wdata;
      end else if (ctrl_en && tick) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (ctrl_auto_reload) begin
          count_q <= load_q;
        end
      end

      if (expire_evt) begin
        expired_q <= 1'b1;
      end else if (wr_status && wdata[STATUS_EXPIRED]) begin
        expired_q <= 1'b0;
      end
    end
  end

  // Read data is driven only during a clean read data phase
  always_comb begin
    rd_data = '0;
    if (dp_valid && !dp_write) begin
      case (dp_offset)
        OFS_CTRL:   rd_data = {29'd0, ctrl_auto_reload, ctrl_irq_en, ctrl_en};
        OFS_LOAD:   rd_data = load_q;
        OFS_COUNT:  rd_data = count_q;
        OFS_STATUS: rd_data = {31'd0, expired_q};
`ifdef RENAS_TIMER_PRESCALER_EN
        OFS_PRESC:  rd_data = {{(32-PRESC_W){1'b0}}, presc_q};
`endif
        default:    rd_data = '0;
      endcase
    end
  end

  assign slave_out = '{hrdata: rd_data, hreadyout: itf_hreadyout, hresp: itf_hresp};
  assign timer_irq = expired_q & ctrl_irq_en;

endmodule
